// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit beside the ALU; owns HI/LO for mfhi/mflo.
// Shift-add mult, restoring div, one bit per cycle, sign fixed up at the end.
// Ports: clk, reset (sync, active-high), Start/Op/Sign/In1/In2 request,
//        Busy/Done status, Hi/Lo result registers.
// Optional macro MDU_EARLY_EXIT_EN: mult stops once the multiplier is spent.
module mdu_iterative #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic             Sign,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    // mult: a=product, b=shifted multiplicand, m=multiplier
    // div:  a={remainder,quotient/dividend}, b[WIDTH-1:0]=divisor
    logic [W2-1:0]    a_q, a_d;
    logic [W2-1:0]    b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] raw_q, raw_d;

    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH:0]   trial;
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quo, rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            raw_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            raw_q   <= raw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        div_d   = div_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        raw_d   = raw_q;
        // 0x80000000 stays 0x80000000 here, read as unsigned 2^31
        abs1    = (Sign && In1[WIDTH-1]) ? -In1 : In1;
        abs2    = (Sign && In2[WIDTH-1]) ? -In2 : In2;
        trial   = {a_q[W2-1:WIDTH], a_q[WIDTH-1]} - {1'b0, b_q[WIDTH-1:0]};
        prod    = neg_q ? -a_q : a_q;
        quo     = a_q[WIDTH-1:0];
        rem     = a_q[W2-1:WIDTH];

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    unique case (Op)
                        2'b10: hi_d = In1;
                        2'b11: lo_d = In1;
                        default: begin
                            div_d   = Op[0];
                            neg_d   = Sign & (In1[WIDTH-1] ^ In2[WIDTH-1]);
                            negr_d  = Sign & In1[WIDTH-1];
                            dz_d    = (In2 == '0);
                            raw_d   = In1;
                            cnt_d   = '0;
                            state_d = S_RUN;
                            if (Op[0]) begin
                                a_d = {{WIDTH{1'b0}}, abs1};
                                b_d = {{WIDTH{1'b0}}, abs2};
                                m_d = '0;
                            end else begin
                                a_d = '0;
                                b_d = {{WIDTH{1'b0}}, abs1};
                                m_d = abs2;
`ifdef MDU_EARLY_EXIT_EN
                                if (abs2 == '0) state_d = S_FIX;
`endif
                            end
                        end
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (div_q) begin
                    // shift in next dividend bit; keep trial if non-negative
                    if (!trial[WIDTH])
                        a_d = {trial[WIDTH-1:0], a_q[WIDTH-2:0], 1'b1};
                    else
                        a_d = {a_q[W2-2:0], 1'b0};
                end else begin
                    if (m_q[0]) a_d = a_q + b_q;
                    b_d = {b_q[W2-2:0], 1'b0};
                    m_d = {1'b0, m_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
`ifdef MDU_EARLY_EXIT_EN
                if (!div_q && m_q[WIDTH-1:1] == '0) state_d = S_FIX;
`endif
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!div_q) begin
                    hi_d = prod[W2-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (dz_q) begin
                    hi_d = raw_q;
                    lo_d = '1;
                end else begin
                    lo_d = neg_q ? -quo : quo;
                    hi_d = negr_q ? -rem : rem;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Busy = (state_q != S_IDLE);
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed mult/div/mthi/mtlo vectors.
// Expected HI/LO and Done cycle are queued at issue, checked on Done.
module tb_mdu_iterative;
    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [1:0]  Op;
    logic        Sign;
    logic [31:0] In1, In2;
    logic        Busy, Done;
    logic [31:0] Hi, Lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   pcyc  = 0;

`ifdef MDU_EARLY_EXIT_EN
    localparam int L0 = 2;
    localparam int L5 = 5;
`else
    localparam int L0 = 34;
    localparam int L5 = 34;
`endif

    mdu_iterative dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .Op    (Op),
        .Sign  (Sign),
        .In1   (In1),
        .In2   (In2),
        .Busy  (Busy),
        .Done  (Done),
        .Hi    (Hi),
        .Lo    (Lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && Done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stray_done: got Done=1 expected 0 (cyc %0d)",
                         pcyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.nm, {Hi, Lo}, {e.hi, e.lo});
                chk({e.nm, "_lat"}, 64'(pcyc), 64'(e.due));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input int lat, input string nm, input bit push);
        @(negedge clk);
        Op = op; Sign = sg; In1 = a; In2 = b; Start = 1'b1;
        if (push) sb.push_back('{eh, el, pcyc + lat, nm});
        @(negedge clk);
        Start = 1'b0;
        Op    = 2'($urandom);
        Sign  = 1'($urandom);
        In1   = $urandom;
        In2   = $urandom;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending expected 0",
                     nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic mt(input logic [1:0] op, input logic [31:0] v,
                      input string nm);
        @(negedge clk);
        Op = op; Sign = 1'b0; In1 = v; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        chk({nm, "_val"}, 64'(op[0] ? Lo : Hi), 64'(v));
        chk({nm, "_busy"}, 64'({Busy, Done}), 64'd0);
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; Op = 2'b00; Sign = 1'b0;
        In1 = '0; In2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", {30'd0, Busy, Done, Hi, Lo}, 64'd0);
        reset = 1'b0;

        mt(2'b10, 32'hAAAA5555, "mthi");
        mt(2'b11, 32'h5A5A5A5A, "mtlo");

        // abort a mult 10 cycles in
        issue(2'b00, 1'b0, 32'd7, 32'd9, '0, '0, 0, "x", 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid", {30'd0, Busy, Done, Hi, Lo}, 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        issue(2'b00, 1'b1, 32'hFFFFFFFD, 32'd7,
              32'hFFFFFFFF, 32'hFFFFFFEB, 34, "mult_s", 1'b1);
        drain("mult_s");
        issue(2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 32'h00000001, 34, "multu", 1'b1);
        drain("multu");
        issue(2'b01, 1'b1, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD, 34, "div_s", 1'b1);
        drain("div_s");
        issue(2'b01, 1'b0, 32'd100, 32'd7,
              32'd2, 32'd14, 34, "divu", 1'b1);
        drain("divu");
        issue(2'b01, 1'b0, 32'h12345678, 32'd0,
              32'h12345678, 32'hFFFFFFFF, 34, "div0_u", 1'b1);
        drain("div0_u");
        issue(2'b01, 1'b1, 32'h87654321, 32'd0,
              32'h87654321, 32'hFFFFFFFF, 34, "div0_s", 1'b1);
        drain("div0_s");
        issue(2'b01, 1'b1, 32'h80000000, 32'hFFFFFFFF,
              32'd0, 32'h80000000, 34, "div_ovf", 1'b1);
        drain("div_ovf");

        // mthi/mtlo while Busy must be dropped
        mt(2'b10, 32'hAAAA5555, "mthi2");
        mt(2'b11, 32'h5A5A5A5A, "mtlo2");
        issue(2'b00, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 34, "mult_b", 1'b1);
        @(negedge clk);
        Op = 2'b11; In1 = 32'hDEADBEEF; Start = 1'b1;
        @(negedge clk);
        Op = 2'b10;
        @(negedge clk);
        Start = 1'b0;
        chk("busy_mt", {Busy, Hi, Lo},
            {1'b1, 32'hAAAA5555, 32'h5A5A5A5A});
        drain("mult_b");

        // back-to-back: second Start in the Done cycle
        issue(2'b00, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 34, "b2b_1", 1'b1);
        begin
            int n;
            n = 0;
            while (!Done && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (!Done) begin
                total++;
                bad++;
                $display("FAIL b2b_wait: got Done=0 expected 1");
            end
        end
        Op = 2'b01; Sign = 1'b0; In1 = 32'd100; In2 = 32'd7; Start = 1'b1;
        sb.push_back('{32'd2, 32'd14, pcyc + 34, "b2b_2"});
        @(negedge clk);
        Start = 1'b0;
        drain("b2b");

        issue(2'b00, 1'b0, 32'd9, 32'd0, 32'd0, 32'd0, L0, "mult_z", 1'b1);
        drain("mult_z");
        issue(2'b00, 1'b0, 32'd9, 32'd5, 32'd0, 32'd45, L5, "mult_5", 1'b1);
        drain("mult_5");
        issue(2'b00, 1'b1, 32'd9, 32'hFFFFFFFB,
              32'hFFFFFFFF, 32'hFFFFFFD3, L5, "mult_n5", 1'b1);
        drain("mult_n5");

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative multiply/divide unit in the execute stage of the multi-cycle CPU, beside the ALU.
- Takes the same In1/In2 operand-register values the ALU consumes and owns the HI/LO registers.
- Hi/Lo feed the ALUOut/writeback mux for mfhi/mflo.
- The controller FSM holds in its execute state while Busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only when not Busy
- Op  input  2  00 mult, 01 div, 10 mthi, 11 mtlo
- Sign  input  1  1 signed (mult/div), 0 unsigned (multu/divu)
- In1  input  32  multiplicand / dividend / mthi-mtlo source
- In2  input  32  multiplier / divisor
- Busy  output  1  high while an operation is in progress
- Done  output  1  one-cycle pulse; new Hi/Lo valid in the same cycle
- Hi  output  32  HI register (upper product / remainder)
- Lo  output  32  LO register (lower product / quotient)

Behaviour:
- Reset (synchronous, active-high, clk rising edge): Hi=0, Lo=0, Busy=0, Done=0, state=IDLE. Reset mid-operation aborts and discards partial results.
- States:
  - IDLE: Done=0 except in the cycle right after FIX.
  - RUN: Busy=1.
  - FIX: Busy=1.
- IDLE, Start=1, Op=10 (mthi): Hi<=In1 at that edge. Stays IDLE; no Busy, no Done.
- IDLE, Start=1, Op=11 (mtlo): Lo<=In1 at that edge. Stays IDLE; no Busy, no Done.
- IDLE, Start=1, Op=0x (mult/div), edge E0:
  - Latch |In1| and |In2|; take absolute values only when Sign=1.
  - Latch result sign bits and the raw In1.
  - Clear the counter; go to RUN.
- RUN, mult: shift-add, one multiplier bit per cycle, 64-bit accumulator.
- RUN, div: restoring division, one quotient bit per cycle, 33-bit partial-remainder subtract.
- RUN runs N=32 iterations (edges E1..E32), then goes to FIX.
- FIX, edge E(N+1):
  - Apply sign correction. mult: negate the 64-bit product if the signs differ. div: quotient negated if signs differ; remainder takes the sign of the dividend.
  - Write Hi/Lo, set Done=1, Busy=0, go to IDLE.
- Timing: mult/div Done is high in the cycle after E33. Busy is high for exactly 33 cycles.
- Done is registered, high for exactly one cycle. Start sampled in that Done cycle is accepted; back-to-back operations are allowed.
- Start while Busy is ignored, including mthi/mtlo; Hi/Lo are not touched.
- Hi/Lo hold their old values throughout RUN/FIX and change only at the FIX edge, at mthi/mtlo, or at reset.
- Div by zero: same latency; Hi=raw In1, Lo=32'hFFFFFFFF regardless of Sign.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. This falls out of the absolute-value method using a 32-bit unsigned magnitude.
- |0x80000000| is treated as unsigned 2^31 throughout.
- In1/In2/Sign/Op may change after E0 without effect.

Optional Feature:
- Macro MDU_EARLY_EXIT_EN.
- Defined: mult leaves RUN once the remaining shifted multiplier magnitude is zero; the check happens before each iteration, including the first. Therefore N = (index of the highest set bit of |In2|) + 1, or 0 when In2=0. Done appears after E(N+1); mult by 0 gives Done after E1. Div and mthi/mtlo are unchanged.
- Undefined: N=32 always; fixed 33-cycle Busy.

Test Plan:
- Reset mid-op: reset after 10 cycles of mult 7x9 -> Busy=0, Done=0, Hi=Lo=0 on the next cycle; no later Done.
- Signed mult: Sign=1, In1=0xFFFFFFFD (-3), In2=7, Start -> Done after E33 with Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Unsigned mult: Sign=0, In1=In2=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- Signed div: Sign=1, In1=-7 (0xFFFFFFF9), In2=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Unsigned divu: In1=100, In2=7 -> Lo=14, Hi=2.
- Div by zero and overflow: In1=0x12345678, In2=0 -> Hi=0x12345678, Lo=0xFFFFFFFF. Sign=1, 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- mthi/mtlo with Start during Busy:
  - mthi In1=0xAAAA5555 from IDLE -> Hi=0xAAAA5555 next cycle, Busy stays 0.
  - mtlo issued while Busy -> Lo unchanged until the FIX write.
- Back-to-back, plus early exit: Start asserted in the Done cycle -> second op accepted, its Done 34 cycles after the first Done. With MDU_EARLY_EXIT_EN, mult In2=0 -> Done after E1; In2=5 -> Done after E4.
